// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meas_pkg;

    typedef enum logic {
        IDLE    = 1'b0,   // no reference edge yet
        MEASURE = 1'b1    // counting since the last rising edge
    } meas_state_t;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned TIMEOUT_DEF     = 65535;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer plus rising-edge detector for slow asynchronous inputs.
// s is the synchronized level, rise is a one-cycle pulse on its 0->1 transition.
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              s_d;

    // Shift the raw input through the synchronizer chain and keep one cycle of history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            s_d    <= sync_q[STAGES-1];
        end
    end

    assign s    = sync_q[STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the rising-to-rising period of a slow asynchronous signal in clk cycles.
// Optional high-time measurement enabled by defining CLK_PERIOD_METER_DUTY_MEAS_EN.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             no_signal
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    meas_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] period_nx;
    logic             valid_nx;
    logic             no_signal_nx;
    logic             timeout_hit;
    logic             rise;

`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
    logic             s_lvl;
`else
    logic             s_lvl_unused;
`endif

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
        .s    (s_lvl),
`else
        .s    (s_lvl_unused),
`endif
        .rise (rise)
    );

    // State and measurement registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            period    <= '0;
            valid     <= 1'b0;
            no_signal <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            period    <= period_nx;
            valid     <= valid_nx;
            no_signal <= no_signal_nx;
        end
    end

    // Next-state logic: arm on the first edge, capture on each later edge, fall back on timeout.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        period_nx    = period;
        valid_nx     = 1'b0;
        no_signal_nx = no_signal;
        timeout_hit  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (rise) begin
                    cnt_nx   = ONE_C;
                    state_nx = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_nx    = cnt;
                    valid_nx     = 1'b1;
                    cnt_nx       = ONE_C;
                    no_signal_nx = 1'b0;
                end else if (cnt == TIMEOUT_C) begin
                    timeout_hit  = 1'b1;
                    state_nx     = IDLE;
                    cnt_nx       = '0;
                    no_signal_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + ONE_C;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] high_q;

    // High-time counter; the rise cycle itself is the first high cycle, so restart at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt   <= '0;
            high_q <= '0;
        end else begin
            if (rise) begin
                hcnt <= ONE_C;
                if (state == MEASURE) begin
                    high_q <= hcnt;
                end
            end else if (timeout_hit) begin
                hcnt <= '0;
            end else if (state == MEASURE && s_lvl) begin
                hcnt <= hcnt + ONE_C;
            end
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: a scoreboard of expected measurements is filled
// as rising edges are driven and drained whenever valid pulses.
// High-time expectations follow CLK_PERIOD_METER_DUTY_MEAS_EN.
module tb_clk_period_meter;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned TMO   = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             no_signal;

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .no_signal (no_signal)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int unsigned per;
        int unsigned hi;
    } meas_t;

    meas_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          armed = 1'b0;
    int unsigned last_rise = 0;
    int unsigned last_h = 0;
    int unsigned last_valid_cyc = 0;
    int unsigned last_exp_per = 0;

    function automatic int unsigned exp_high(input int unsigned h);
`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
        return h;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic  prev_v;
        meas_t m;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                check("valid_width", 32'(prev_v), 0);
                check("valid_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    m = sb.pop_front();
                    check("period", 32'(period), m.per);
                    check("high_time", 32'(high_time), m.hi);
                    check("no_signal_on_valid", 32'(no_signal), 0);
                    last_exp_per   = m.per;
                    last_valid_cyc = cyc;
                end
            end
            prev_v = valid;
        end
    endtask

    // One sig_in pulse: high for h cycles then low for l; entered and left at #1 after a posedge.
    task automatic pulse(input int unsigned h, input int unsigned l);
        meas_t m;
        if (armed && (cyc - last_rise) <= TMO) begin
            m.per = cyc - last_rise;
            m.hi  = exp_high(last_h);
            sb.push_back(m);
        end
        armed     = 1'b1;
        last_rise = cyc;
        last_h    = h;
        sig_in    = 1'b1;
        repeat (h) @(posedge clk);
        #1 sig_in = 1'b0;
        repeat (l) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", 32'(period), 0);
        check("rst_high_time", 32'(high_time), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_no_signal", 32'(no_signal), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Steady toggle every 8 cycles.
        pulse(8, 8);
        check("no_signal_after_first_edge", 32'(no_signal), 1);
        pulse(8, 8);
        check("no_signal_after_second_edge", 32'(no_signal), 0);
        repeat (3) pulse(8, 8);

        // Period change 16 -> 10 with a single 13-cycle transitional period.
        pulse(8, 5);
        repeat (4) pulse(5, 5);

        // Hold low until timeout.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (no_signal === 1'b1) break;
        end
        check("timeout_no_signal", 32'(no_signal), 1);
        check("timeout_latency", cyc - last_valid_cyc, TMO);
        check("timeout_period_kept", 32'(period), last_exp_per);
        check("timeout_sb_empty", sb.size(), 0);

        // Restart: first edge only re-arms.
        @(posedge clk);
        #1;
        pulse(8, 8);
        check("restart_no_signal", 32'(no_signal), 1);
        repeat (2) pulse(8, 8);

        // Asynchronous reset mid-period.
        check("pre_reset_sb_empty", sb.size(), 0);
        rst = 1'b1;
        #1;
        check("async_rst_period", 32'(period), 0);
        check("async_rst_no_signal", 32'(no_signal), 1);
        check("async_rst_valid", 32'(valid), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        armed = 1'b0;
        pulse(8, 8);
        check("post_reset_no_signal", 32'(no_signal), 1);
        repeat (3) pulse(8, 8);

        // High 3 / low 5.
        repeat (4) pulse(3, 5);

        // Period just over TIMEOUT is dropped, exactly TIMEOUT is measured.
        pulse(51, 50);
        pulse(50, 50);
        pulse(50, 50);
        pulse(50, 50);
        check("boundary_no_signal", 32'(no_signal), 0);
        pulse(8, 8);

        repeat (10) @(posedge clk);
        #1;
        check("final_sb_empty", sb.size(), 0);
        check("final_no_signal", 32'(no_signal), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
